if_branch_predictor: RTL and testbench

- Dynamic branch predictor with branch target buffer (BTB). Sits directly upstream of the IF stage PC register.
- Each cycle it looks up the current fetch PC and supplies a predicted next PC. The EX stage later resolves the branch and trains the table through an update port.
- The block also generates the misprediction redirect.
- It implements branch prediction strategy 'b11 (DYNAMIC) of CPU_Pipelined, alongside the existing 00 NOT TAKEN, 01 TAKEN and 10 DELAY SLOT strategies.

---
 rtl/cpu_pipe_pkg.sv | 25 ++
 rtl/sat_counter2.sv | 25 ++
 rtl/if_branch_predictor.sv | 145 ++++++++++++++
 tb/tb_if_branch_predictor.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared constants for the pipelined CPU front end: branch strategy codes,
// 2-bit predictor counter encodings and the sequential PC increment.
package cpu_pipe_pkg;

  // Branch strategy select, as driven by the pipeline configuration.
  localparam logic [1:0] BP_NOT_TAKEN = 2'b00;
  localparam logic [1:0] BP_TAKEN     = 2'b01;
  localparam logic [1:0] BP_DELAY     = 2'b10;
  localparam logic [1:0] BP_DYNAMIC   = 2'b11;

  // Saturating counter encodings; bit 1 is the taken/not-taken prediction.
  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  // Fall-through distance between sequential instructions.
  localparam logic [31:0] PC_INC = 32'd4;

  // Sequential successor of a PC.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/sat_counter2.sv
// Next-state function of a 2-bit saturating branch counter.
// force_st_i wins over inc_i/dec_i; the counter never wraps.
module sat_counter2
  import cpu_pipe_pkg::*;
(
  input  logic [1:0] cnt_i,
  input  logic       inc_i,
  input  logic       dec_i,
  input  logic       force_st_i,
  output logic [1:0] cnt_o
);

  // Saturating increment/decrement with an override to strong-taken.
  always_comb begin
    cnt_o = cnt_i;
    if (force_st_i) begin
      cnt_o = CNT_ST;
    end else if (inc_i && (cnt_i != CNT_ST)) begin
      cnt_o = cnt_i + 2'd1;
    end else if (dec_i && (cnt_i != CNT_SNT)) begin
      cnt_o = cnt_i - 2'd1;
    end
  end

endmodule

// File: rtl/if_branch_predictor.sv
// Dynamic branch predictor with a direct-mapped BTB. Looks up the fetch PC
// combinationally, is trained by the EX stage, and produces the mispredict
// redirect plus branch/mispredict performance counters.
module if_branch_predictor
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned IDX_W = 4,
  parameter int unsigned TAG_W = 26,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [31:0]      if_pc,
  output logic             pred_hit,
  output logic             pred_taken,
  output logic [31:0]      pred_next_pc,
  input  logic             ex_valid,
  input  logic             ex_is_jump,
  input  logic [31:0]      ex_pc,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  input  logic             ex_pred_taken,
  input  logic [31:0]      ex_pred_target,
  output logic             mispredict,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mp_count
);

  localparam int unsigned Entries = 1 << IDX_W;

  // BTB storage
  logic             valid_q  [Entries];
  logic [TAG_W-1:0] tag_q    [Entries];
  logic [31:0]      target_q [Entries];
  logic [1:0]       cnt_q    [Entries];

  logic [CNT_W-1:0] br_count_q;
  logic [CNT_W-1:0] mp_count_q;

  // Lookup side
  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[31:IDX_W+2];

  // Zero-latency prediction; reads pre-update contents (no write bypass).
  always_comb begin
    pred_hit     = en & valid_q[if_idx] & (tag_q[if_idx] == if_tag);
    pred_taken   = pred_hit & cnt_q[if_idx][1];
    pred_next_pc = pred_taken ? target_q[if_idx] : pc_plus4(if_pc);
  end

  // Misprediction detection and redirect, independent of en.
  always_comb begin
    mispredict  = 1'b0;
    redirect_pc = 32'd0;
    if (ex_valid) begin
      mispredict  = (ex_taken != ex_pred_taken) |
                    (ex_taken & (ex_pred_target != ex_target));
      redirect_pc = ex_taken ? ex_target : pc_plus4(ex_pc);
    end
  end

  // Training side
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_hit;
  logic [1:0]       hit_cnt_next;
  logic             upd_we;
  logic [1:0]       upd_cnt_d;
  logic [31:0]      upd_target_d;

  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[31:IDX_W+2];
  assign ex_hit = valid_q[ex_idx] & (tag_q[ex_idx] == ex_tag);

  sat_counter2 u_sat_counter2 (
    .cnt_i      (cnt_q[ex_idx]),
    .inc_i      (ex_taken),
    .dec_i      (~ex_taken),
    .force_st_i (ex_is_jump),
    .cnt_o      (hit_cnt_next)
  );

  // Decide what the resolving instruction writes into its BTB slot.
  always_comb begin
    upd_we       = 1'b0;
    upd_cnt_d    = cnt_q[ex_idx];
    upd_target_d = target_q[ex_idx];
    if (ex_valid) begin
      if (ex_hit) begin
        upd_we    = 1'b1;
        upd_cnt_d = hit_cnt_next;
        // A not-taken conditional keeps its old target.
        if (ex_is_jump || ex_taken) begin
          upd_target_d = ex_target;
        end
      end else if (ex_taken) begin
        // Allocate by overwriting whatever aliased into this slot.
        upd_we       = 1'b1;
        upd_cnt_d    = ex_is_jump ? CNT_ST : CNT_WT;
        upd_target_d = ex_target;
      end
    end
  end

  // BTB table register; asynchronous clear drops any in-flight update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < Entries; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= 32'd0;
        cnt_q[i]    <= CNT_WNT;
      end
    end else if (upd_we) begin
      valid_q[ex_idx]  <= 1'b1;
      tag_q[ex_idx]    <= ex_tag;
      target_q[ex_idx] <= upd_target_d;
      cnt_q[ex_idx]    <= upd_cnt_d;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      br_count_q <= '0;
      mp_count_q <= '0;
    end else begin
      if (ex_valid && (br_count_q != '1)) begin
        br_count_q <= br_count_q + CNT_W'(1);
      end
      if (mispredict && (mp_count_q != '1)) begin
        mp_count_q <= mp_count_q + CNT_W'(1);
      end
    end
  end

  assign br_count = br_count_q;
  assign mp_count = mp_count_q;

endmodule

// File: tb/tb_if_branch_predictor.sv
// Directed bench for if_branch_predictor. Inputs change on the falling edge
// and outputs are checked 1 time unit later, well away from the rising edge.
module tb_if_branch_predictor;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] if_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_next_pc;
  logic        ex_valid;
  logic        ex_is_jump;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [15:0] br_count;
  logic [15:0] mp_count;

  int tests_run;
  int tests_failed;

  if_branch_predictor #(
    .IDX_W (4),
    .TAG_W (26),
    .CNT_W (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .if_pc          (if_pc),
    .pred_hit       (pred_hit),
    .pred_taken     (pred_taken),
    .pred_next_pc   (pred_next_pc),
    .ex_valid       (ex_valid),
    .ex_is_jump     (ex_is_jump),
    .ex_pc          (ex_pc),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc),
    .br_count       (br_count),
    .mp_count       (mp_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_ex(input logic v, input logic jmp, input logic [31:0] pc,
                          input logic tkn, input logic [31:0] tgt,
                          input logic ptkn, input logic [31:0] ptgt);
    ex_valid       = v;
    ex_is_jump     = jmp;
    ex_pc          = pc;
    ex_taken       = tkn;
    ex_target      = tgt;
    ex_pred_taken  = ptkn;
    ex_pred_target = ptgt;
  endtask

  task automatic idle_ex();
    drive_ex(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst   = 1'b0;
    en    = 1'b1;
    if_pc = 32'd28;
    idle_ex();

    // Reset state
    #1;
    check("rst_hit", 32'(pred_hit), 32'd0);
    check("rst_next_pc", pred_next_pc, 32'd32);
    check("rst_mispredict", 32'(mispredict), 32'd0);
    check("rst_redirect", redirect_pc, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rel_hit", 32'(pred_hit), 32'd0);
    check("rel_taken", 32'(pred_taken), 32'd0);
    check("rel_next_pc", pred_next_pc, 32'd32);
    check("rel_br_count", 32'(br_count), 32'd0);
    check("rel_mp_count", 32'(mp_count), 32'd0);

    // Jump train at 72 -> 24 (idx 2, tag 1)
    @(negedge clk);
    drive_ex(1'b1, 1'b1, 32'd72, 1'b1, 32'd24, 1'b0, 32'd76);
    #1;
    check("jmp_mispredict", 32'(mispredict), 32'd1);
    check("jmp_redirect", redirect_pc, 32'd24);
    @(negedge clk);
    idle_ex();
    if_pc = 32'd72;
    #1;
    check("jmp_hit", 32'(pred_hit), 32'd1);
    check("jmp_taken", 32'(pred_taken), 32'd1);
    check("jmp_next_pc", pred_next_pc, 32'd24);
    check("jmp_mp_count", 32'(mp_count), 32'd1);
    check("jmp_br_count", 32'(br_count), 32'd1);

    // Alias: same idx, tag 0
    if_pc = 32'd8;
    #1;
    check("alias_hit", 32'(pred_hit), 32'd0);
    check("alias_next_pc", pred_next_pc, 32'd12);

    // Hysteresis on beq at 60 -> 72: T (alloc 10)
    @(negedge clk);
    drive_ex(1'b1, 1'b0, 32'd60, 1'b1, 32'd72, 1'b0, 32'd64);
    #1;
    check("beq1_mispredict", 32'(mispredict), 32'd1);
    // T again (10 -> 11), correctly predicted
    @(negedge clk);
    idle_ex();
    if_pc = 32'd60;
    #1;
    check("beq_wt_taken", 32'(pred_taken), 32'd1);
    check("beq_wt_next_pc", pred_next_pc, 32'd72);
    drive_ex(1'b1, 1'b0, 32'd60, 1'b1, 32'd72, 1'b1, 32'd72);
    #1;
    check("beq2_mispredict", 32'(mispredict), 32'd0);
    // N (11 -> 10)
    @(negedge clk);
    drive_ex(1'b1, 1'b0, 32'd60, 1'b0, 32'd72, 1'b1, 32'd72);
    #1;
    check("beq3_mispredict", 32'(mispredict), 32'd1);
    check("beq3_redirect", redirect_pc, 32'd64);
    @(negedge clk);
    idle_ex();
    #1;
    check("beq_hyst_hit", 32'(pred_hit), 32'd1);
    check("beq_hyst_taken", 32'(pred_taken), 32'd1);
    check("beq_hyst_next_pc", pred_next_pc, 32'd72);
    // N again (10 -> 01)
    drive_ex(1'b1, 1'b0, 32'd60, 1'b0, 32'd72, 1'b1, 32'd72);
    #1;
    check("beq4_mispredict", 32'(mispredict), 32'd1);
    @(negedge clk);
    idle_ex();
    #1;
    check("beq_wnt_hit", 32'(pred_hit), 32'd1);
    check("beq_wnt_taken", 32'(pred_taken), 32'd0);
    check("beq_wnt_next_pc", pred_next_pc, 32'd64);
    check("beq_br_count", 32'(br_count), 32'd5);
    check("beq_mp_count", 32'(mp_count), 32'd4);

    // Simultaneous lookup and allocate at 28 -> 80
    @(negedge clk);
    if_pc = 32'd28;
    drive_ex(1'b1, 1'b0, 32'd28, 1'b1, 32'd80, 1'b0, 32'd32);
    #1;
    check("sim_same_cycle_hit", 32'(pred_hit), 32'd0);
    check("sim_same_cycle_next", pred_next_pc, 32'd32);
    @(negedge clk);
    idle_ex();
    #1;
    check("sim_next_hit", 32'(pred_hit), 32'd1);
    check("sim_next_pc", pred_next_pc, 32'd80);

    // Target mismatch with correct direction still mispredicts
    @(negedge clk);
    drive_ex(1'b1, 1'b1, 32'd72, 1'b1, 32'd24, 1'b1, 32'd100);
    #1;
    check("tgt_mispredict", 32'(mispredict), 32'd1);
    check("tgt_redirect", redirect_pc, 32'd24);
    @(negedge clk);
    idle_ex();
    #1;
    check("tgt_br_count", 32'(br_count), 32'd7);
    check("tgt_mp_count", 32'(mp_count), 32'd6);

    // en=0 with a trained entry at 72
    en    = 1'b0;
    if_pc = 32'd72;
    #1;
    check("dis_hit", 32'(pred_hit), 32'd0);
    check("dis_taken", 32'(pred_taken), 32'd0);
    check("dis_next_pc", pred_next_pc, 32'd76);
    check("dis_mispredict", 32'(mispredict), 32'd0);
    check("dis_redirect", redirect_pc, 32'd0);

    // Reset asserted while an update is in flight
    @(negedge clk);
    drive_ex(1'b1, 1'b0, 32'd60, 1'b1, 32'd200, 1'b0, 32'd64);
    #1;
    rst = 1'b0;
    #1;
    check("mid_rst_br_count", 32'(br_count), 32'd0);
    check("mid_rst_mp_count", 32'(mp_count), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    idle_ex();
    en    = 1'b1;
    if_pc = 32'd72;
    #1;
    check("post_rst_hit72", 32'(pred_hit), 32'd0);
    check("post_rst_next72", pred_next_pc, 32'd76);
    if_pc = 32'd60;
    #1;
    check("post_rst_hit60", 32'(pred_hit), 32'd0);
    check("post_rst_next60", pred_next_pc, 32'd64);
    if_pc = 32'd28;
    #1;
    check("post_rst_hit28", 32'(pred_hit), 32'd0);
    check("post_rst_br_count", 32'(br_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
